// File: rtl/sha2_pad.sv
// SHA-256 message padder: turns a byte-masked AXI-Stream message into complete
// padded 512-bit blocks (0x80, zero fill, 64-bit big-endian bit length).
module sha2_pad #(
    parameter int unsigned LEN_W = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [511:0]     s_axis_tdata,
    input  logic [63:0]      s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [511:0]     m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             err_keep,
    output logic [CNT_W-1:0] msg_count
);
    typedef enum logic [0:0] {StPass, StExtra} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-4:0] len_q, len_d, len_sum;
    logic [LEN_W-1:0] len_bits, pend_len_q, pend_len_d;
    logic             pend_lead_q, pend_lead_d;
    logic [511:0]     data_q, data_d, last_blk, extra_blk;
    logic             vld_q, vld_d, last_q, last_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       n_bytes;
    logic [63:0]      keep_inc;
    logic             out_free, accept, illegal;

    assign out_free      = !vld_q || m_axis_tready;
    assign s_axis_tready = (state_q == StPass) && out_free && !areset;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // A legal last-beat mask is 0..01..1, so adding one never overlaps it.
    assign keep_inc = s_axis_tkeep + 64'd1;
    assign illegal  = s_axis_tlast ? |(keep_inc & s_axis_tkeep) : (s_axis_tkeep != '1);

    always_comb begin
        n_bytes = '0;
        for (int i = 0; i < 64; i++) begin
            n_bytes = n_bytes + 7'(s_axis_tkeep[i]);
        end
    end

    assign len_sum  = len_q + (LEN_W-3)'(n_bytes);
    assign len_bits = {len_sum, 3'b000};

    always_comb begin
        last_blk = '0;
        for (int i = 0; i < 64; i++) begin
            if (7'(i) < n_bytes) begin
                last_blk[8*i +: 8] = s_axis_tdata[8*i +: 8];
            end else if (7'(i) == n_bytes) begin
                last_blk[8*i +: 8] = 8'h80;
            end
        end
        if (n_bytes <= 7'd55) begin
            for (int j = 0; j < 8; j++) begin
                last_blk[8*(56+j) +: 8] = len_bits[8*(7-j) +: 8];
            end
        end
    end

    always_comb begin
        extra_blk        = '0;
        extra_blk[7:0]   = pend_lead_q ? 8'h80 : 8'h00;
        for (int j = 0; j < 8; j++) begin
            extra_blk[8*(56+j) +: 8] = pend_len_q[8*(7-j) +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pend_len_d  = pend_len_q;
        pend_lead_d = pend_lead_q;
        data_d      = data_q;
        last_d      = last_q;
        vld_d       = vld_q && !m_axis_tready;
        err_d       = 1'b0;
        cnt_d       = cnt_q + CNT_W'(vld_q && m_axis_tready && last_q);
        if (out_free) begin
            if (state_q == StExtra) begin
                data_d  = extra_blk;
                last_d  = 1'b1;
                vld_d   = 1'b1;
                state_d = StPass;
            end else if (accept) begin
                vld_d = 1'b1;
                err_d = illegal;
                if (!s_axis_tlast) begin
                    data_d = s_axis_tdata;
                    last_d = 1'b0;
                    len_d  = len_sum;
                end else begin
                    data_d = last_blk;
                    len_d  = '0;
                    if (n_bytes <= 7'd55) begin
                        last_d = 1'b1;
                    end else begin
                        // Length does not fit: it goes out in a trailing block.
                        last_d      = 1'b0;
                        state_d     = StExtra;
                        pend_len_d  = len_bits;
                        pend_lead_d = (n_bytes == 7'd64);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StPass;
            len_q       <= '0;
            pend_len_q  <= '0;
            pend_lead_q <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pend_len_q  <= pend_len_d;
            pend_lead_q <= pend_lead_d;
            data_q      <= data_d;
            last_q      <= last_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tlast  = last_q;
    assign err_keep      = err_q;
    assign msg_count     = cnt_q;
endmodule

// File: tb/tb_sha2_pad.sv
// Directed bench for sha2_pad: hand-computed padded blocks checked with
// immediate assertions; a monitor queues every accepted output block.
module tb_sha2_pad;
    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic         err_keep;
    logic [31:0]  msg_count;

    int errors = 0;
    int checks = 0;
    bit stall_en = 0;
    logic [512:0] outq[$];

    sha2_pad #(.LEN_W(64), .CNT_W(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_keep      (err_keep),
        .msg_count     (msg_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tlast, m_axis_tdata});
    end

    always @(negedge aclk) begin
        if (stall_en) m_axis_tready = 1'($urandom_range(0, 1));
    end

    function automatic logic [511:0] setb(input logic [511:0] b, input int i, input logic [7:0] v);
        b[8*i +: 8] = v;
        return b;
    endfunction

    // Byte i = base + i for i < n, remaining bytes filled with junk 0xEE.
    function automatic logic [511:0] pat(input int base, input int n, input bit junk);
        logic [511:0] b = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) b[8*i +: 8] = 8'(base + i);
            else if (junk) b[8*i +: 8] = 8'hEE;
        end
        return b;
    endfunction

    function automatic logic [511:0] lenblk(input logic [511:0] b, input logic [7:0] hi,
                                            input logic [7:0] lo);
        return setb(setb(b, 62, hi), 63, lo);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] exp, input logic exp_last);
        logic [512:0] got;
        for (int c = 0; c < 300 && outq.size() == 0; c++) @(posedge aclk);
        checks++;
        if (outq.size() == 0) begin
            errors++;
            $display("FAIL %s: got no block expected %h", tag, exp);
            return;
        end
        got = outq.pop_front();
        assert (got === {exp_last, exp}) else begin
            errors++;
            $error("FAIL %s: got last=%b %h expected last=%b %h", tag, got[512], got[511:0],
                   exp_last, exp);
        end
    endtask

    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
        bit ok;
        for (int c = 0; c < 300; c++) begin
            @(negedge aclk);
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = l;
            s_axis_tvalid = 1'b1;
            #1 ok = s_axis_tready;
            @(posedge aclk);
            #1;
            if (ok) begin
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        errors++;
        checks++;
        $display("FAIL send: got no tready expected accept");
        s_axis_tvalid = 1'b0;
    endtask

    logic [511:0] abc_in, abc_exp, d56, da, db;

    initial begin
        abc_in  = setb(setb(setb(pat(0, 0, 1), 0, 8'h61), 1, 8'h62), 2, 8'h63);
        abc_exp = setb(setb(setb(setb(setb('0, 0, 8'h61), 1, 8'h62), 2, 8'h63), 3, 8'h80), 63, 8'h18);
        d56     = pat(1, 56, 1);
        da      = pat(8'h10, 64, 0);
        db      = pat(8'h50, 64, 0);

        repeat (3) @(negedge aclk);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata_lo", m_axis_tdata[63:0], 64'd0);
        chk("rst_err", 64'(err_keep), 64'd0);
        chk("rst_count", 64'(msg_count), 64'd0);
        areset = 1'b0;

        // Empty message with junk data
        send('1, 64'h0, 1'b1);
        chk_blk("empty", 512'h80, 1'b1);
        @(negedge aclk);
        chk("count_empty", 64'(msg_count), 64'd1);

        send(abc_in, 64'h7, 1'b1);
        chk_blk("abc", abc_exp, 1'b1);

        // 56 bytes: length spills into an extra block, input stalls one cycle
        send(d56, 64'h00FF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge aclk);
        chk("extra_stall", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        chk("extra_resume", 64'(s_axis_tready), 64'd1);
        chk_blk("m56_b1", setb(pat(1, 56, 0), 56, 8'h80), 1'b0);
        chk_blk("m56_b2", lenblk('0, 8'h01, 8'hC0), 1'b1);

        send(da, '1, 1'b0);
        send(db, '1, 1'b1);
        chk_blk("m128_b1", da, 1'b0);
        chk_blk("m128_b2", db, 1'b0);
        chk_blk("m128_b3", lenblk(512'h80, 8'h04, 8'h00), 1'b1);
        @(negedge aclk);
        chk("count_4", 64'(msg_count), 64'd4);

        // Back-to-back 3/56/130-byte messages under random downstream stalls
        stall_en = 1;
        send(abc_in, 64'h7, 1'b1);
        send(d56, 64'h00FF_FFFF_FFFF_FFFF, 1'b1);
        send(da, '1, 1'b0);
        send(db, '1, 1'b0);
        send(pat(8'hA0, 2, 1), 64'h3, 1'b1);
        @(negedge aclk);
        stall_en = 0;
        m_axis_tready = 1'b1;
        chk_blk("bb_abc", abc_exp, 1'b1);
        chk_blk("bb_56a", setb(pat(1, 56, 0), 56, 8'h80), 1'b0);
        chk_blk("bb_56b", lenblk('0, 8'h01, 8'hC0), 1'b1);
        chk_blk("bb_130a", da, 1'b0);
        chk_blk("bb_130b", db, 1'b0);
        chk_blk("bb_130c", lenblk(setb(pat(8'hA0, 2, 0), 2, 8'h80), 8'h04, 8'h10), 1'b1);
        repeat (3) @(negedge aclk);
        chk("bb_count", 64'(msg_count), 64'd7);
        chk("bb_no_extra", 64'(outq.size()), 64'd0);

        // Illegal keep on a non-last beat, then reset mid-message
        send(da, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        @(negedge aclk);
        chk("err_pulse", 64'(err_keep), 64'd1);
        @(negedge aclk);
        chk("err_clear", 64'(err_keep), 64'd0);
        send(db, '1, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata_hi", m_axis_tdata[511:448], 64'd0);
        chk("mid_rst_count", 64'(msg_count), 64'd0);
        areset = 1'b0;
        outq.delete();
        send(abc_in, 64'h7, 1'b1);
        chk_blk("abc_after_rst", abc_exp, 1'b1);
        @(negedge aclk);
        chk("count_after_rst", 64'(msg_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
